rr_arbiter8: RTL and testbench

//   8-way round-robin arbiter that shares one downstream resource between eight requesters.

---
 rtl/rr_arbiter8_pkg.sv | 39 +++
 rtl/rr_arbiter8_decoder.sv | 17 +
 rtl/rr_arbiter8.sv | 115 +++++++++++
 tb/tb_rr_arbiter8.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/rr_arbiter8_pkg.sv
// Shared definitions for the 8-way round-robin arbiter.
//   - FSM state encoding (IDLE / GRANT / GAP, 2 bits)
//   - requester count and grant-index width
//   - rr_pick(): rotating-priority search used by the arbiter top
package rr_arbiter8_pkg;

  localparam int N_REQ = 8;
  localparam int ID_W  = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  typedef struct packed {
    logic            found;
    logic [ID_W-1:0] id;
  } pick_t;

  // First requester at or after ptr, wrapping modulo N_REQ.
  // The loop runs from the farthest offset down to offset 0 so that the
  // last assignment to win is the nearest requester to ptr.
  function automatic pick_t rr_pick(input logic [N_REQ-1:0] req,
                                    input logic [ID_W-1:0]  ptr);
    pick_t           res;
    logic [ID_W-1:0] idx;
    res = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = ptr + ID_W'(k);
      if (req[idx]) begin
        res.found = 1'b1;
        res.id    = idx;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_arbiter8_decoder.sv
// 3-to-8 one-hot decoder.
//   sel    in  3  binary index
//   onehot out 8  bit sel set, all others clear
module rr_arbiter8_decoder
  import rr_arbiter8_pkg::*;
(
  input  logic [ID_W-1:0]  sel,
  output logic [N_REQ-1:0] onehot
);

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_dec
      assign onehot[gi] = (sel == ID_W'(gi));
    end
  endgenerate

endmodule

// File: rtl/rr_arbiter8.sv
// 8-way round-robin arbiter with bounded hold time and a one-cycle
// turnaround gap between owners.
//   clk       in   1  rising-edge clock
//   rst       in   1  synchronous active-high reset
//   enable    in   1  allows new grants from IDLE/GAP; ignored in GRANT
//   req       in   8  request vector, bit i = requester i
//   gnt       out  8  one-hot grant while gnt_valid, else zero
//   gnt_id    out  3  current / last owner index
//   gnt_valid out  1  high while in GRANT
//   forced    out  1  one-cycle pulse after an owner is released by timeout
// Parameters:
//   MAX_HOLD  max consecutive GRANT cycles per owner (0 = unlimited)
//   HOLD_W    hold counter width, MAX_HOLD <= 2**HOLD_W-1
module rr_arbiter8
  import rr_arbiter8_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int HOLD_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_id,
  output logic             gnt_valid,
  output logic             forced
);

  // Counter value seen on the last allowed GRANT cycle.
  localparam logic [HOLD_W-1:0] HOLD_LAST =
    HOLD_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

  state_e             state_q,    state_d;
  logic [ID_W-1:0]    ptr_q,      ptr_d;
  logic [ID_W-1:0]    gnt_id_q,   gnt_id_d;
  logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic               forced_q,   forced_d;

  pick_t              pick;
  logic               arb_ok;
  logic               owner_req;
  logic               timeout;
  logic [N_REQ-1:0]   dec_onehot;

  assign pick      = rr_pick(req, ptr_q);
  assign arb_ok    = enable && pick.found;
  assign owner_req = req[gnt_id_q];
  assign timeout   = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST);

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    gnt_id_d   = gnt_id_q;
    hold_cnt_d = hold_cnt_q;
    forced_d   = 1'b0;

    unique case (state_q)
      ST_GRANT: begin
        // A voluntary release wins over a timeout on the same edge, so
        // forced is only raised when the owner is still requesting.
        if (!owner_req) begin
          state_d = ST_GAP;
          ptr_d   = gnt_id_q + ID_W'(1);
        end else if (timeout) begin
          state_d  = ST_GAP;
          ptr_d    = gnt_id_q + ID_W'(1);
          forced_d = 1'b1;
        end
        if (hold_cnt_q != '1) begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      ST_IDLE, ST_GAP: begin
        if (arb_ok) begin
          state_d    = ST_GRANT;
          gnt_id_d   = pick.id;
          hold_cnt_d = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      gnt_id_q   <= '0;
      hold_cnt_q <= '0;
      forced_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gnt_id_q   <= gnt_id_d;
      hold_cnt_q <= hold_cnt_d;
      forced_q   <= forced_d;
    end
  end

  rr_arbiter8_decoder u_dec (
    .sel    (gnt_id_q),
    .onehot (dec_onehot)
  );

  assign gnt_valid = (state_q == ST_GRANT);
  assign gnt       = dec_onehot & {N_REQ{gnt_valid}};
  assign gnt_id    = gnt_id_q;
  assign forced    = forced_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
module tb_rr_arbiter8;

  localparam int MAX_HOLD = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_valid;
  logic       forced;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: who owns the resource, how long they have held it,
  // and where the next search starts.
  int m_mode;      // 0 = nobody, 1 = someone owns, 2 = turnaround cycle
  int m_owner;
  int m_held;      // grant cycles already completed by the owner
  int m_ptr;
  bit m_forced;

  always #5 clk = ~clk;

  rr_arbiter8 #(.MAX_HOLD(MAX_HOLD), .HOLD_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .req       (req),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid),
    .forced    (forced)
  );

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Apply the arbiter's rules to the inputs present at this edge.
  task automatic model_edge();
    bit found;
    if (rst) begin
      m_mode = 0; m_ptr = 0; m_owner = 0; m_held = 0; m_forced = 0;
      return;
    end
    m_forced = 0;
    if (m_mode == 1) begin
      if (!req[m_owner]) begin
        m_mode = 2;
        m_ptr  = (m_owner + 1) % 8;
      end else if (MAX_HOLD != 0 && m_held + 1 == MAX_HOLD) begin
        m_mode   = 2;
        m_ptr    = (m_owner + 1) % 8;
        m_forced = 1;
      end else begin
        m_held++;
      end
    end else begin
      found = 0;
      if (enable && req != 0) begin
        for (int k = 0; k < 8; k++) begin
          if (!found && req[(m_ptr + k) % 8]) begin
            found   = 1;
            m_owner = (m_ptr + k) % 8;
          end
        end
      end
      if (found) begin
        m_mode = 1;
        m_held = 0;
        $display("grant owner=%0d req=%02h t=%0t", m_owner, req, $time);
      end else begin
        m_mode = 0;
      end
    end
  endtask

  task automatic compare_all();
    logic [7:0] exp_gnt;
    exp_gnt = (m_mode == 1) ? 8'(1 << m_owner) : 8'h00;
    check_val("gnt",       gnt,       exp_gnt);
    check_val("gnt_valid", gnt_valid, (m_mode == 1));
    check_val("gnt_id",    gnt_id,    m_owner);
    check_val("forced",    forced,    m_forced);
  endtask

  // One clock: model follows the edge, outputs sampled 1 ns later.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  int owners[$];
  int n_forced;
  int n_gap;
  bit prev_valid;

  initial begin
    rst = 1'b1; enable = 1'b1; req = 8'hFF;
    m_mode = 0; m_ptr = 0; m_owner = 0; m_held = 0; m_forced = 0;

    // 1: reset for two edges with all requests high
    step();
    step();
    check_val("rst_gnt", gnt, 8'h00);

    // 2: single request, then release -> one gap cycle, then idle
    rst = 1'b0; req = 8'h04;
    step();
    check_val("s2_gnt", gnt, 8'h04);
    check_val("s2_id", gnt_id, 3'd2);
    req = 8'h00;
    step();
    check_val("s2_gap", gnt, 8'h00);
    step();
    step();

    // 3: full load, owners rotate with timeouts and one gap between owners
    rst = 1'b1; req = 8'hFF; step();
    rst = 1'b0;
    n_forced = 0; n_gap = 0; prev_valid = 0;
    for (int s = 0; s < 80; s++) begin
      step();
      if (gnt_valid && !prev_valid) owners.push_back(int'(gnt_id));
      if (forced) n_forced++;
      if (gnt == 8'h00) n_gap++;
      prev_valid = gnt_valid;
    end
    check_val("s3_owner_cnt", owners.size(), 9);
    for (int i = 0; i < 9 && i < owners.size(); i++)
      check_val($sformatf("s3_owner%0d", i), owners[i], i % 8);
    check_val("s3_forced_cnt", n_forced, 8);
    check_val("s3_gap_cnt", n_gap, 8);

    // 4: owner 7 releases, pointer wraps to 0
    rst = 1'b1; req = 8'h00; step();
    rst = 1'b0; req = 8'h80; step();
    check_val("s4_own7", gnt, 8'h80);
    req = 8'h03; step();
    check_val("s4_gap", gnt, 8'h00);
    step();
    check_val("s4_wrap", gnt, 8'h01);
    req = 8'h02; step(); step();
    check_val("s4_next", gnt, 8'h02);
    req = 8'h00; step(); step();

    // 5: enable gating
    enable = 1'b0; req = 8'h10; step(); step();
    check_val("s5_blocked", gnt, 8'h00);
    enable = 1'b1; step();
    check_val("s5_grant", gnt, 8'h10);
    enable = 1'b0; step(); step(); step();
    check_val("s5_held", gnt, 8'h10);
    req = 8'h00; step(); step();
    enable = 1'b1;

    // 6: reset during a grant
    req = 8'h20; step();
    check_val("s6_own5", gnt, 8'h20);
    rst = 1'b1; req = 8'h21; step();
    check_val("s6_rst", gnt, 8'h00);
    rst = 1'b0; step();
    check_val("s6_after", gnt, 8'h01);

    // Randomized traffic against the model
    for (int s = 0; s < 3000; s++) begin
      rst = ($urandom_range(0, 63) == 0);
      enable = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 3) == 0) req = 8'($urandom);
      else if ($urandom_range(0, 3) == 0) req = req & ~gnt;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
